// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC-3 memory controller.
// Holds the controller FSM state enum and the memory-mapped I/O page addresses.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } mem_state_e;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    // True for any address in the I/O page (xFE00 and above).
    function automatic logic is_mmio(input logic [15:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard, display and machine-control registers of the LC-3 I/O page.
// Only instantiated when LC3_MMIO_EN is defined.
// i_acc is a one-cycle strobe on the edge that enters the controller's DONE state, so
// every side effect (KBSR clear, DDR load, MCR update) is visible during DONE.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_acc,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_we,
    output logic [15:0] o_rdata,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    output logic        o_ddr_valid,
    output logic [7:0]  o_ddr_data,
    input  logic        i_disp_ready,
    output logic        o_mcr_run
);

    logic       kb_rdy_q, kb_rdy_d;
    logic       kb_ie_q, kb_ie_d;
    logic [7:0] kb_char_q, kb_char_d;
    logic       ddr_vld_q, ddr_vld_d;
    logic [7:0] ddr_char_q, ddr_char_d;
    logic       mcr_run_q, mcr_run_d;
    logic       kbdr_rd, kbsr_wr, ddr_wr, mcr_wr;

    // Only KBSR[14], DDR[7:0] and MCR[15] are writable.
    logic unused_wdata;
    assign unused_wdata = ^i_wdata[13:8];

    // Register next-state: keyboard set beats a same-cycle KBDR read, DDR write beats handshake.
    always_comb begin
        kbdr_rd    = i_acc && !i_we && (i_addr == ADDR_KBDR);
        kbsr_wr    = i_acc &&  i_we && (i_addr == ADDR_KBSR);
        ddr_wr     = i_acc &&  i_we && (i_addr == ADDR_DDR);
        mcr_wr     = i_acc &&  i_we && (i_addr == ADDR_MCR);
        kb_rdy_d   = kb_rdy_q;
        kb_ie_d    = kb_ie_q;
        kb_char_d  = kb_char_q;
        ddr_vld_d  = ddr_vld_q;
        ddr_char_d = ddr_char_q;
        mcr_run_d  = mcr_run_q;

        if (i_kb_valid && (!kb_rdy_q || kbdr_rd)) begin
            kb_rdy_d  = 1'b1;
            kb_char_d = i_kb_data;
        end else if (kbdr_rd) begin
            kb_rdy_d  = 1'b0;
        end
        if (kbsr_wr) kb_ie_d = i_wdata[14];

        if (ddr_wr) begin
            ddr_vld_d  = 1'b1;
            ddr_char_d = i_wdata[7:0];
        end else if (ddr_vld_q && i_disp_ready) begin
            ddr_vld_d  = 1'b0;
        end

        if (mcr_wr) mcr_run_d = i_wdata[15];
    end

    // Read mux reflects register state before this access's own side effects.
    always_comb begin
        o_rdata = '0;
        unique case (i_addr)
            ADDR_KBSR: o_rdata = {kb_rdy_q, kb_ie_q, 14'b0};
            ADDR_KBDR: o_rdata = {8'b0, kb_char_q};
            ADDR_DSR:  o_rdata = {~ddr_vld_q, 15'b0};
            ADDR_MCR:  o_rdata = {mcr_run_q, 15'b0};
            default:   o_rdata = '0;
        endcase
    end

    // Device register state with synchronous reset; the machine comes up running.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            kb_rdy_q   <= 1'b0;
            kb_ie_q    <= 1'b0;
            kb_char_q  <= '0;
            ddr_vld_q  <= 1'b0;
            ddr_char_q <= '0;
            mcr_run_q  <= 1'b1;
        end else begin
            kb_rdy_q   <= kb_rdy_d;
            kb_ie_q    <= kb_ie_d;
            kb_char_q  <= kb_char_d;
            ddr_vld_q  <= ddr_vld_d;
            ddr_char_q <= ddr_char_d;
            mcr_run_q  <= mcr_run_d;
        end
    end

    assign o_ddr_valid = ddr_vld_q;
    assign o_ddr_data  = ddr_char_q;
    assign o_mcr_run   = mcr_run_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: word-addressed LC-3 main memory behind the MAR/MDR wrapper.
// Accepts a level-held WE/RE, completes after MEM_LATENCY cycles with a one-cycle
// o_READY pulse, then waits for the request to drop so it is never re-executed.
// Define LC3_MMIO_EN to decode the xFE00+ I/O page (KBSR/KBDR/DSR/DDR/MCR);
// without it every address maps to RAM and the device ports are inert.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int    DEPTH_LOG2  = 16,
    parameter int    MEM_LATENCY = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_WE,
    input  logic        i_RE,
    input  logic [15:0] i_ADDR,
    input  logic [15:0] i_D,
    output logic [15:0] o_D_OUT,
    output logic        o_READY,
    input  logic        i_KB_VALID,
    input  logic [7:0]  i_KB_DATA,
    output logic        o_DDR_VALID,
    output logic [7:0]  o_DDR_DATA,
    input  logic        i_DISP_READY,
    output logic        o_MCR_RUN
);

`ifdef LC3_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    mem_state_e                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [15:0]               addr_q, addr_d;
    logic [15:0]               data_q, data_d;
    logic                      we_q, we_d;
    logic                      ready_q, ready_d;
    logic [15:0]               d_out_q, d_out_d;
    logic                      acc_fire, acc_mmio;
    logic [DEPTH_LOG2-1:0]     ram_idx;
    logic [15:0]               mmio_rdata;

    logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

    // RAM starts cleared.
    initial begin
        for (int i = 0; i < (2**DEPTH_LOG2); i++) mem[i] = '0;
    end

    // FSM next state; addr_d/data_d/we_d are the live access operands (inputs at accept, latched later).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_WE || i_RE) begin
                    addr_d  = i_ADDR;
                    data_d  = i_D;
                    we_d    = i_WE;
                    cnt_d   = CNT_LOAD;
                    state_d = (MEM_LATENCY == 1 || (MMIO_EN && is_mmio(i_ADDR))) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_HOLD;
            ST_HOLD: if (!i_WE && !i_RE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The access itself happens on the edge into DONE so data and side effects are valid with READY.
    always_comb begin
        acc_fire = (state_d == ST_DONE);
        acc_mmio = MMIO_EN && is_mmio(addr_d);
        ram_idx  = addr_d[DEPTH_LOG2-1:0];
        ready_d  = acc_fire;
        d_out_d  = d_out_q;
        if (acc_fire && !we_d) d_out_d = acc_mmio ? mmio_rdata : mem[ram_idx];
    end

    // Controller state, latched operands and outputs; synchronous active-low reset.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            d_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            d_out_q <= d_out_d;
        end
    end

    // RAM write port; gated by reset so an aborted access never commits.
    always_ff @(posedge i_CLK) begin
        if (i_RST_N && acc_fire && we_d && !acc_mmio) mem[ram_idx] <= data_d;
    end

    assign o_READY = ready_q;
    assign o_D_OUT = d_out_q;

`ifdef LC3_MMIO_EN
    lc3_mmio_regs u_mmio (
        .i_clk        (i_CLK),
        .i_rst_n      (i_RST_N),
        .i_acc        (acc_fire && acc_mmio && i_RST_N),
        .i_addr       (addr_d),
        .i_wdata      (data_d),
        .i_we         (we_d),
        .o_rdata      (mmio_rdata),
        .i_kb_valid   (i_KB_VALID),
        .i_kb_data    (i_KB_DATA),
        .o_ddr_valid  (o_DDR_VALID),
        .o_ddr_data   (o_DDR_DATA),
        .i_disp_ready (i_DISP_READY),
        .o_mcr_run    (o_MCR_RUN)
    );
`else
    logic unused_dev;
    assign unused_dev  = ^{i_KB_VALID, i_KB_DATA, i_DISP_READY};
    assign mmio_rdata  = '0;
    assign o_DDR_VALID = 1'b0;
    assign o_DDR_DATA  = '0;
    assign o_MCR_RUN   = 1'b1;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed + randomized checks of lc3_mem_ctrl (latency 2) against a
// behavioural memory model. I/O page checks follow whether LC3_MMIO_EN is defined.
module tb_lc3_mem_ctrl;

    localparam int LAT = 2;
`ifdef LC3_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        i_CLK = 1'b0;
    logic        i_RST_N = 1'b0;
    logic        i_WE = 1'b0, i_RE = 1'b0;
    logic [15:0] i_ADDR = '0, i_D = '0;
    logic        i_KB_VALID = 1'b0;
    logic [7:0]  i_KB_DATA = '0;
    logic        i_DISP_READY = 1'b0;
    logic [15:0] o_D_OUT;
    logic        o_READY, o_DDR_VALID, o_MCR_RUN;
    logic [7:0]  o_DDR_DATA;

    int checks = 0, passes = 0, fails = 0;
    logic [15:0] mdl [int];
    logic        run_rdy;

    always #5 i_CLK = ~i_CLK;

    lc3_mem_ctrl #(.DEPTH_LOG2(16), .MEM_LATENCY(LAT), .INIT_FILE("")) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_WE(i_WE), .i_RE(i_RE),
        .i_ADDR(i_ADDR), .i_D(i_D), .o_D_OUT(o_D_OUT), .o_READY(o_READY),
        .i_KB_VALID(i_KB_VALID), .i_KB_DATA(i_KB_DATA),
        .o_DDR_VALID(o_DDR_VALID), .o_DDR_DATA(o_DDR_DATA),
        .i_DISP_READY(i_DISP_READY), .o_MCR_RUN(o_MCR_RUN)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] a);
        return (MMIO && a >= 16'hFE00) ? 1 : LAT;
    endfunction

    // One access: idle two cycles so the FSM is back in IDLE, raise the request,
    // count cycles until READY, sample results, drop the request.
    task automatic xfer(input logic we, input logic re, input logic [15:0] a, input logic [15:0] wd,
                        input logic kbv, input logic [7:0] kbc,
                        output logic [15:0] rdv, output int lat);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_WE = we; i_RE = re; i_ADDR = a; i_D = wd;
        i_KB_VALID = kbv; i_KB_DATA = kbc;
        lat = 0;
        do begin
            @(negedge i_CLK);
            i_KB_VALID = 1'b0;
            lat++;
        end while (!o_READY && lat < 20);
        rdv = o_D_OUT;
        run_rdy = o_MCR_RUN;
        i_WE = 1'b0; i_RE = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] r;
        int l;
        xfer(1'b1, 1'b0, a, d, 1'b0, 8'h00, r, l);
        check({tag, " lat"}, 16'(l), 16'(exp_lat(a)));
        if (!(MMIO && a >= 16'hFE00)) mdl[int'(a)] = d;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] r;
        int l;
        xfer(1'b0, 1'b1, a, 16'h0000, 1'b0, 8'h00, r, l);
        check({tag, " lat"}, 16'(l), 16'(exp_lat(a)));
        check({tag, " data"}, r, exp);
    endtask

    task automatic kb_pulse(input logic [7:0] c);
        @(negedge i_CLK);
        i_KB_VALID = 1'b1; i_KB_DATA = c;
        @(negedge i_CLK);
        i_KB_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r, a;
        int          l, pulses;

        // Reset values
        repeat (3) @(negedge i_CLK);
        check("rst ready", 16'(o_READY), 16'h0000);
        check("rst dout", o_D_OUT, 16'h0000);
        check("rst ddr_valid", 16'(o_DDR_VALID), 16'h0000);
        check("rst ddr_data", 16'(o_DDR_DATA), 16'h0000);
        check("rst mcr_run", 16'(o_MCR_RUN), 16'h0001);
        i_RST_N = 1'b1;

        // Basic write then read, latency LAT each
        wr("wr 3000", 16'h3000, 16'h1234);
        rd("rd 3000", 16'h3000, 16'h1234);

        // Request held across completion: one READY pulse only
        wr("wr 3001", 16'h3001, 16'hBEEF);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_RE = 1'b1; i_ADDR = 16'h3001;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_CLK);
            if (o_READY) pulses++;
            if (i == 4) i_ADDR = 16'h3000;
        end
        check("hold pulses", 16'(pulses), 16'd1);
        check("hold dout kept", o_D_OUT, 16'hBEEF);
        i_RE = 1'b0;
        @(negedge i_CLK);
        check("hold ready low", 16'(o_READY), 16'h0000);
        rd("after hold", 16'h3000, 16'h1234);

        // WE and RE together: write wins
        wr("pre 3002", 16'h3002, 16'h1111);
        xfer(1'b1, 1'b1, 16'h3002, 16'h7777, 1'b0, 8'h00, r, l);
        check("both lat", 16'(l), 16'(LAT));
        mdl[32'h3002] = 16'h7777;
        rd("both rd", 16'h3002, mdl[32'h3002]);

        // Address/data changes during BUSY are ignored
        wr("pre 3004", 16'h3004, 16'h4444);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_WE = 1'b1; i_ADDR = 16'h3003; i_D = 16'hCAFE;
        @(negedge i_CLK);
        i_ADDR = 16'h3004; i_D = 16'h0BAD;
        l = 1;
        while (!o_READY && l < 20) begin
            @(negedge i_CLK);
            l++;
        end
        check("busy chg lat", 16'(l), 16'(LAT));
        i_WE = 1'b0;
        mdl[32'h3003] = 16'hCAFE;
        rd("busy chg 3003", 16'h3003, mdl[32'h3003]);
        rd("busy chg 3004", 16'h3004, mdl[32'h3004]);

        // Top of RAM just below the I/O page
        wr("wr FDFF", 16'hFDFF, 16'h5AA5);
        rd("rd FDFF", 16'hFDFF, 16'h5AA5);

        // Randomized RAM traffic against the model
        for (int i = 0; i < 40; i++) begin
            a = 16'h5000 + 16'($urandom_range(0, 15));
            if (!mdl.exists(int'(a)) || $urandom_range(0, 1) == 0)
                wr("rnd wr", a, 16'($urandom));
            else
                rd("rnd rd", a, mdl[int'(a)]);
        end

`ifdef LC3_MMIO_EN
        // Keyboard
        kb_pulse(8'h41);
        rd("KBSR set", 16'hFE00, 16'h8000);
        kb_pulse(8'h42);
        rd("KBDR", 16'hFE02, 16'h0041);
        rd("KBSR clr", 16'hFE00, 16'h0000);
        wr("KBSR ie", 16'hFE00, 16'hFFFF);
        rd("KBSR ie rd", 16'hFE00, 16'h4000);
        kb_pulse(8'h43);
        xfer(1'b0, 1'b1, 16'hFE02, 16'h0000, 1'b1, 8'h44, r, l);
        check("KBDR coll lat", 16'(l), 16'd1);
        check("KBDR coll old", r, 16'h0043);
        rd("KBSR coll", 16'hFE00, 16'hC000);
        rd("KBDR new", 16'hFE02, 16'h0044);
        rd("KBSR clr2", 16'hFE00, 16'h4000);

        // Display
        i_DISP_READY = 1'b0;
        wr("DDR", 16'hFE06, 16'h0048);
        check("ddr valid", 16'(o_DDR_VALID), 16'h0001);
        check("ddr data", 16'(o_DDR_DATA), 16'h0048);
        rd("DSR busy", 16'hFE04, 16'h0000);
        wr("DDR ovw", 16'hFE06, 16'h0049);
        check("ddr ovw valid", 16'(o_DDR_VALID), 16'h0001);
        check("ddr ovw data", 16'(o_DDR_DATA), 16'h0049);
        @(negedge i_CLK);
        i_DISP_READY = 1'b1;
        @(negedge i_CLK);
        check("ddr handshake", 16'(o_DDR_VALID), 16'h0000);
        i_DISP_READY = 1'b0;
        rd("DSR ready", 16'hFE04, 16'h8000);

        // Machine control
        wr("MCR", 16'hFFFE, 16'h0000);
        check("mcr run in done", 16'(run_rdy), 16'h0000);
        rd("MCR rd", 16'hFFFE, 16'h0000);

        // Unmapped I/O addresses
        rd("other rd", 16'hFE08, 16'h0000);
        wr("other wr", 16'hFE10, 16'h1234);
        rd("other rd2", 16'hFE10, 16'h0000);
`else
        // I/O page is plain RAM; device ports inert
        wr("ram FE00", 16'hFE00, 16'h9999);
        rd("ram FE00", 16'hFE00, 16'h9999);
        kb_pulse(8'h41);
        rd("ram FE00 kb", 16'hFE00, 16'h9999);
        wr("ram FE06", 16'hFE06, 16'h0048);
        check("noio ddr valid", 16'(o_DDR_VALID), 16'h0000);
        check("noio ddr data", 16'(o_DDR_DATA), 16'h0000);
        wr("ram FFFE", 16'hFFFE, 16'h0000);
        check("noio mcr run", 16'(run_rdy), 16'h0001);
        rd("ram FFFE", 16'hFFFE, 16'h0000);
`endif

        // Reset in BUSY aborts an uncommitted write
        wr("pre 4000", 16'h4000, 16'h5555);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_WE = 1'b1; i_ADDR = 16'h4000; i_D = 16'hAAAA;
        @(negedge i_CLK);
        i_RST_N = 1'b0;
        @(negedge i_CLK);
        check("abort ready", 16'(o_READY), 16'h0000);
        check("abort mcr_run", 16'(o_MCR_RUN), 16'h0001);
        check("abort dout", o_D_OUT, 16'h0000);
        i_WE = 1'b0;
        @(negedge i_CLK);
        check("abort ready2", 16'(o_READY), 16'h0000);
        i_RST_N = 1'b1;
        rd("abort 4000", 16'h4000, mdl[32'h4000]);
        rd("post rst 3000", 16'h3000, mdl[32'h3000]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
